// File: rtl/note_sequencer.sv
// note_sequencer
// ---------------------------------------------------------------------------
// Plays a run-time programmable sequence of notes as a 1-bit square wave.
// Each memory entry holds {half-period, duration in tempo ticks, last flag}.
// A half-period of 0 is a rest. Playback runs IDLE -> LOAD -> PLAY per note,
// with optional looping back to entry 0 at the end of the sequence.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high; clears state and outputs (not memory)
//   start     begin playback at entry 0 (only honoured in IDLE)
//   stop      abort playback; wins over start
//   loop_en   sampled at sequence end: 1 = restart at entry 0, 0 = finish
//   wr_en     note memory write strobe
//   wr_addr   entry written
//   wr_hp     half-period in clocks (0 = rest)
//   wr_dur    duration in ticks (0 behaves as 1)
//   wr_last   entry terminates the sequence
//   tone_out  square wave to speaker mux
//   busy      high in LOAD and PLAY
//   done      one-cycle pulse on natural completion
//   note_idx  entry currently loaded/playing
// ---------------------------------------------------------------------------
module note_sequencer #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 8,
  parameter int DEPTH   = 16,
  parameter int HP_W    = 20,
  parameter int DUR_W   = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [HP_W-1:0]  wr_hp,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             wr_last,
  output logic             tone_out,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    note_idx
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW       = HP_W + DUR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // Memory word layout: {hp, dur, last}
  logic [MW-1:0]    mem_r [DEPTH];
  logic [MW-1:0]    rd_word_s;

  state_t           state_r;
  logic [HP_W-1:0]  hp_r;
  logic [DUR_W-1:0] dur_r;
  logic             last_r;
  logic [TW-1:0]    tick_cnt_r;
  logic [DUR_W-1:0] dur_cnt_r;
  logic [HP_W-1:0]  phase_r;

  logic [DUR_W-1:0] dur_eff_s;
  logic             tick_wrap_s;
  logic             note_end_s;
  logic             seq_end_s;
  logic             phase_wrap_s;

  // Combinational read at the current index; a write landing on the LOAD
  // edge is therefore not seen until that entry's next LOAD.
  assign rd_word_s    = mem_r[note_idx];

  assign dur_eff_s    = (dur_r == {DUR_W{1'b0}}) ? DUR_W'(1) : dur_r;
  assign tick_wrap_s  = (tick_cnt_r == TW'(TICK_DIV - 1));
  // Last PLAY cycle of the note: the tick wraps onto the final duration count.
  assign note_end_s   = tick_wrap_s && (dur_cnt_r == (dur_eff_s - DUR_W'(1)));
  // Sequence ends on an explicit last flag or on the final memory entry.
  assign seq_end_s    = last_r || (note_idx == AW'(DEPTH - 1));
  assign phase_wrap_s = (phase_r == (hp_r - HP_W'(1)));

  // Note memory write port; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= {wr_hp, wr_dur, wr_last};
    end
  end

  // Playback FSM, tempo/duration/phase counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      hp_r       <= {HP_W{1'b0}};
      dur_r      <= {DUR_W{1'b0}};
      last_r     <= 1'b0;
      tick_cnt_r <= {TW{1'b0}};
      dur_cnt_r  <= {DUR_W{1'b0}};
      phase_r    <= {HP_W{1'b0}};
      tone_out   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      note_idx   <= {AW{1'b0}};
    end else if (stop) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= {TW{1'b0}};
      dur_cnt_r  <= {DUR_W{1'b0}};
      phase_r    <= {HP_W{1'b0}};
      tone_out   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      note_idx   <= {AW{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tone_out <= 1'b0;
          if (start) begin
            note_idx <= {AW{1'b0}};
            busy     <= 1'b1;
            state_r  <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          hp_r       <= rd_word_s[MW-1 -: HP_W];
          dur_r      <= rd_word_s[DUR_W:1];
          last_r     <= rd_word_s[0];
          tick_cnt_r <= {TW{1'b0}};
          dur_cnt_r  <= {DUR_W{1'b0}};
          phase_r    <= {HP_W{1'b0}};
          tone_out   <= 1'b0;
          busy       <= 1'b1;
          state_r    <= ST_PLAY;
        end

        ST_PLAY: begin
          if (note_end_s) begin
            tick_cnt_r <= {TW{1'b0}};
            dur_cnt_r  <= {DUR_W{1'b0}};
            phase_r    <= {HP_W{1'b0}};
            tone_out   <= 1'b0;
            if (!seq_end_s) begin
              note_idx <= note_idx + AW'(1);
              state_r  <= ST_LOAD;
            end else if (loop_en) begin
              note_idx <= {AW{1'b0}};
              state_r  <= ST_LOAD;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            if (tick_wrap_s) begin
              tick_cnt_r <= {TW{1'b0}};
              dur_cnt_r  <= dur_cnt_r + DUR_W'(1);
            end else begin
              tick_cnt_r <= tick_cnt_r + TW'(1);
            end
            // Rest notes keep the output low and the phase counter idle.
            if (hp_r != {HP_W{1'b0}}) begin
              if (phase_wrap_s) begin
                phase_r  <= {HP_W{1'b0}};
                tone_out <= ~tone_out;
              end else begin
                phase_r  <= phase_r + HP_W'(1);
              end
            end else begin
              phase_r  <= {HP_W{1'b0}};
              tone_out <= 1'b0;
            end
          end
        end

        default: begin
          state_r  <= ST_IDLE;
          tone_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [19:0] wr_hp = 20'd0;
  logic [3:0]  wr_dur = 4'd0;
  logic        wr_last = 1'b0;
  logic        tone_out;
  logic        busy;
  logic        done;
  logic [1:0]  note_idx;

  int total = 0;
  int bad = 0;

  note_sequencer #(
    .CLK_HZ (64),
    .TICK_HZ(4),
    .DEPTH  (4),
    .HP_W   (20),
    .DUR_W  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_hp   (wr_hp),
    .wr_dur  (wr_dur),
    .wr_last (wr_last),
    .tone_out(tone_out),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [19:0] hp, input logic [3:0] d, input logic l);
    wr_en = 1'b1; wr_addr = a; wr_hp = hp; wr_dur = d; wr_last = l;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total++;
    if (tone_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got tone=%b busy=%b done=%b idx=%0d exp 0/0/0/0", tone_out, busy, done, note_idx);
    end
    step();
    total++;
    if (busy !== 1'b0 || tone_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b tone=%b exp 0/0", busy, tone_out);
    end
  endtask

  // Observation k: k edges after the edge that sampled start (k=1 is LOAD).
  task automatic test_one_shot();
    logic exp_tone, exp_busy, exp_done;
    logic [1:0] exp_idx;
    wr(2'd0, 20'd2, 4'd1, 1'b0);
    wr(2'd1, 20'd0, 4'd2, 1'b1);
    loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      exp_busy = (k <= 50);
      exp_done = (k == 51);
      exp_tone = (k >= 2 && k <= 17) && ((((k - 2) / 2) % 2) == 1);
      exp_idx  = (k <= 17) ? 2'd0 : 2'd1;
      total++;
      if (tone_out !== exp_tone) begin
        bad++; $display("FAIL one_shot_tone k=%0d got=%b exp=%b", k, tone_out, exp_tone);
      end
      total++;
      if (busy !== exp_busy || done !== exp_done) begin
        bad++; $display("FAIL one_shot_busy_done k=%0d got=%b/%b exp=%b/%b", k, busy, done, exp_busy, exp_done);
      end
      if (k <= 50) begin
        total++;
        if (note_idx !== exp_idx) begin
          bad++; $display("FAIL one_shot_idx k=%0d got=%0d exp=%0d", k, note_idx, exp_idx);
        end
      end
      start = (k == 10);  // start while busy must be ignored
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_loop();
    logic exp_tone, exp_busy, exp_done;
    logic [1:0] exp_idx;
    int m;
    loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      m = (k <= 100) ? (((k - 1) % 50) + 1) : 51;
      exp_busy = (m <= 50);
      exp_done = (m == 51);
      exp_tone = (m >= 2 && m <= 17) && ((((m - 2) / 2) % 2) == 1);
      exp_idx  = (m <= 17) ? 2'd0 : 2'd1;
      total++;
      if (tone_out !== exp_tone || busy !== exp_busy || done !== exp_done) begin
        bad++;
        $display("FAIL loop k=%0d got tone=%b busy=%b done=%b exp %b/%b/%b", k, tone_out, busy, done, exp_tone, exp_busy, exp_done);
      end
      if (m <= 50) begin
        total++;
        if (note_idx !== exp_idx) begin
          bad++; $display("FAIL loop_idx k=%0d got=%0d exp=%0d", k, note_idx, exp_idx);
        end
      end
      if (k == 60) loop_en = 1'b0;
      step();
    end
  endtask

  task automatic test_implicit_end();
    logic exp_tone, exp_busy, exp_done;
    int n, j;
    for (int a = 0; a < 4; a++) wr(2'(a), 20'd1, 4'd1, 1'b0);
    loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      exp_busy = (k <= 68);
      exp_done = (k == 69);
      total++;
      if (busy !== exp_busy || done !== exp_done) begin
        bad++; $display("FAIL implicit_busy_done k=%0d got=%b/%b exp=%b/%b", k, busy, done, exp_busy, exp_done);
      end
      if (k <= 68) begin
        n = (k - 1) / 17;
        j = k - (1 + 17 * n);
        exp_tone = (j >= 1) && (((j - 1) % 2) == 1);
        total++;
        if (tone_out !== exp_tone || note_idx !== 2'(n)) begin
          bad++; $display("FAIL implicit_tone_idx k=%0d got=%b/%0d exp=%b/%0d", k, tone_out, note_idx, exp_tone, n);
        end
      end
      step();
    end
  endtask

  task automatic test_dur_zero();
    logic exp_tone, exp_busy, exp_done;
    wr(2'd0, 20'd3, 4'd0, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      exp_busy = (k <= 17);
      exp_done = (k == 18);
      exp_tone = (k >= 2 && k <= 17) && ((((k - 2) / 3) % 2) == 1);
      total++;
      if (tone_out !== exp_tone || busy !== exp_busy || done !== exp_done) begin
        bad++;
        $display("FAIL dur_zero k=%0d got tone=%b busy=%b done=%b exp %b/%b/%b", k, tone_out, busy, done, exp_tone, exp_busy, exp_done);
      end
      step();
    end
  endtask

  task automatic test_stop();
    wr(2'd0, 20'd2, 4'd1, 1'b0);
    wr(2'd1, 20'd0, 4'd2, 1'b1);
    loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    total++;
    if (tone_out !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL stop_pre got tone=%b busy=%b exp 1/1", tone_out, busy);
    end
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (tone_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== 2'd0) begin
      bad++; $display("FAIL stop_post got tone=%b busy=%b done=%b idx=%0d exp 0/0/0/0", tone_out, busy, done, note_idx);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || tone_out !== 1'b0) begin
        bad++; $display("FAIL stop_idle k=%0d got done=%b busy=%b tone=%b exp 0/0/0", k, done, busy, tone_out);
      end
    end
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL start_stop_same got busy=%b exp 0", busy);
    end
    // Stop during the second note must return the index to 0.
    start = 1'b1; step(); start = 1'b0;
    for (int k = 2; k <= 20; k++) step();
    total++;
    if (note_idx !== 2'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL stop_note1_pre got idx=%0d busy=%b exp 1/1", note_idx, busy);
    end
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (note_idx !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL stop_note1_post got idx=%0d busy=%b done=%b exp 0/0/0", note_idx, busy, done);
    end
  endtask

  task automatic test_write_while_playing();
    wr(2'd0, 20'd2, 4'd1, 1'b0);
    wr(2'd1, 20'd0, 4'd2, 1'b1);
    loop_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    // Overwrite entry 0 on the same edge that loads it: old contents play.
    wr_en = 1'b1; wr_addr = 2'd0; wr_hp = 20'd0; wr_dur = 4'd1; wr_last = 1'b1;
    step();
    wr_en = 1'b0;
    step(); step();
    total++;
    if (tone_out !== 1'b1) begin
      bad++; $display("FAIL wr_load_old k=4 got tone=%b exp 1", tone_out);
    end
    for (int k = 5; k <= 8; k++) step();
    total++;
    if (tone_out !== 1'b1) begin
      bad++; $display("FAIL wr_load_old k=8 got tone=%b exp 1", tone_out);
    end
    stop = 1'b1; step(); stop = 1'b0;
    // Next start picks up the new contents: a single rest with last set.
    start = 1'b1; step(); start = 1'b0;
    for (int k = 2; k <= 18; k++) begin
      step();
      if (k == 4 || k == 9) begin
        total++;
        if (tone_out !== 1'b0) begin
          bad++; $display("FAIL wr_new_rest k=%0d got tone=%b exp 0", k, tone_out);
        end
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL wr_new_done got done=%b busy=%b exp 1/0", done, busy);
    end
    step();
  endtask

  task automatic test_reset_mid_play();
    logic exp_tone;
    wr(2'd0, 20'd2, 4'd1, 1'b0);
    wr(2'd1, 20'd0, 4'd2, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    reset = 1'b1; step(); reset = 1'b0;
    total++;
    if (tone_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || note_idx !== 2'd0) begin
      bad++; $display("FAIL reset_mid got tone=%b busy=%b done=%b idx=%0d exp 0/0/0/0", tone_out, busy, done, note_idx);
    end
    step(); step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_idle got busy=%b exp 0", busy);
    end
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp_tone = (k >= 2) && ((((k - 2) / 2) % 2) == 1);
      total++;
      if (tone_out !== exp_tone || busy !== 1'b1 || note_idx !== 2'd0) begin
        bad++; $display("FAIL reset_replay k=%0d got tone=%b busy=%b idx=%0d exp %b/1/0", k, tone_out, busy, note_idx, exp_tone);
      end
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_loop();
    test_implicit_end();
    test_dur_zero();
    test_stop();
    test_write_while_playing();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Programmable, parametrised successor to the fixed-melody song generator. It plays a sequence of notes from an internal note memory written at run time. Each note carries its own pitch (half-period in clocks), its duration in tempo ticks, and an end-of-sequence flag. Pitch 0 encodes a rest. It supports start/stop control, one-shot or looped playback, and status outputs, and drives the same 1-bit square-wave speaker path as the free-play tone generator, via the existing output mux.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- TICK_HZ, 8, tempo tick rate; TICK_DIV = CLK_HZ/TICK_HZ clocks per tick (integer, ≥2)
- DEPTH, 16, note memory entries (power of 2, ≥2); AW = log2(DEPTH)
- HP_W, 20, half-period field width
- DUR_W, 4, duration field width (ticks)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  begin playback at entry 0 (honoured only in IDLE)
- stop  in  1  abort playback immediately
- loop_en  in  1  sampled at sequence end: 1 = restart at entry 0, 0 = finish
- wr_en  in  1  write note memory
- wr_addr  in  AW  entry written
- wr_hp  in  HP_W  half-period in clocks; 0 = rest
- wr_dur  in  DUR_W  duration in ticks; 0 treated as 1
- wr_last  in  1  entry ends the sequence
- tone_out  out  1  square wave to speaker mux
- busy  out  1  high in LOAD and PLAY
- done  out  1  one-cycle pulse on natural (non-stopped, non-looping) completion
- note_idx  out  AW  address of the entry currently loaded/playing

## Operation
- Note memory is DEPTH×(HP_W+DUR_W+1). It is written synchronously on wr_en and read combinationally at note_idx. Reset does not clear it.
- States: IDLE, LOAD, PLAY.
- IDLE: on start (and no stop), note_idx←0, go to LOAD.
- LOAD (exactly 1 cycle):
  - Latch hp/dur/last from memory[note_idx].
  - Clear tick_cnt, dur_cnt and phase counter; tone_out←0.
  - Go to PLAY.
- PLAY:
  - tick_cnt counts 0..TICK_DIV-1. On wrap, dur_cnt increments.
  - When dur_cnt reaches max(dur,1), the note ends in that cycle:
    - last=0 and note_idx<DEPTH-1: note_idx+1, go to LOAD.
    - last=1, or note_idx=DEPTH-1 (implicit end): if loop_en, note_idx←0 and go to LOAD; otherwise go to IDLE with done=1 for the next cycle.
- Tone, in PLAY with hp≠0: the phase counter counts 0..hp-1; at hp-1 it clears and tone_out toggles. Output frequency is CLK_HZ/(2·hp). hp=1 toggles every cycle.
- Rest (hp=0): tone_out held 0 for the note duration.
- tone_out is 0 in IDLE and LOAD.
- stop in any state: next cycle IDLE, tone_out=0, busy=0, done=0, note_idx←0. stop beats start in the same cycle.
- start while busy is ignored.
- A write to the entry being played does not disturb the current note; it takes effect on that entry's next LOAD. A write in the same cycle as LOAD of that address loads the old contents.

## Timing
- Reset values: tone_out=0, busy=0, done=0, note_idx=0, state IDLE, all counters 0.
- start sampled at edge N: LOAD during cycle N+1 with busy=1; PLAY from N+2.
- Each note occupies 1 LOAD cycle + max(dur,1)·TICK_DIV PLAY cycles.
- First toggle of a pitched note comes hp cycles after PLAY begins.
- done and busy=0 appear in the cycle after the final PLAY cycle. done lasts exactly 1 cycle. It never asserts on loop restart or on stop.
- Counters: tick_cnt width ⌈log2 TICK_DIV⌉, dur_cnt DUR_W, phase HP_W. None wraps beyond its bound.

## Test plan
Bench parameters: CLK_HZ=64, TICK_HZ=4 (TICK_DIV=16), DEPTH=4.

- Entry0 {hp=2,dur=1,last=0}, entry1 {hp=0,dur=2,last=1}; start at cycle 0 -> LOAD at 1; entry0 PLAY cycles 2–17 with tone_out toggling every 2 cycles (4 full periods); LOAD at 18; rest cycles 19–50 with tone_out=0; done=1 only at cycle 51; busy 1→0 at 51.
- Same memory, loop_en=1 -> at cycle 51 note_idx=0 and LOAD (no done); pattern repeats with period 50 cycles.
- No entry has last set, all dur=1 -> plays entries 0..3, then done (implicit end at DEPTH-1).
- Entry with dur=0 -> lasts exactly 16 PLAY cycles, same as dur=1.
- stop mid-note at PLAY cycle 5 -> next cycle IDLE, tone_out=0, no done; start and stop together in IDLE -> stays IDLE.
- Reset asserted mid-PLAY -> next cycle all outputs 0; memory retained; a following start replays entry 0 unchanged.
